// File: rtl/control_sequencer.sv
// Microprogram control sequencer: RUN/HALT FSM plus a registered 7-bit
// control state that addresses the microstore. Each microinstruction's Mode
// picks the next state: increment, dispatch, jump, conditional branch,
// fetch, MOC wait or halt.
//
// Optional feature: define WAIT_TIMEOUT_EN to bound MOC waits. A stall that
// lasts TIMEOUT cycles sends the sequencer to FAULT_STATE and sets the sticky
// Mem_Fault flag. Without the macro, MOC waits stall indefinitely, Mem_Fault
// is tied low and no counter logic is built.
module control_sequencer #(
  parameter logic [6:0]  FETCH_STATE = 7'd1,
  parameter int unsigned TIMEOUT     = 15,
  parameter logic [6:0]  FAULT_STATE = 7'd127
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [6:0] State_Sel,
  input  logic [2:0] Mode,
  input  logic [6:0] Jump_Addr,
  input  logic       Cond,
  input  logic       Moc,
  output logic [6:0] State,
  output logic       Waiting,
  output logic       Halted,
  output logic       Mem_Fault
);

  typedef enum logic {StRun, StHalt} fsm_e;

  localparam logic [2:0] ModeIncr     = 3'b000;
  localparam logic [2:0] ModeDispatch = 3'b001;
  localparam logic [2:0] ModeJump     = 3'b010;
  localparam logic [2:0] ModeBrt      = 3'b011;
  localparam logic [2:0] ModeFetch    = 3'b100;
  localparam logic [2:0] ModeWaitMoc  = 3'b101;
  localparam logic [2:0] ModeBrf      = 3'b110;
  localparam logic [2:0] ModeHalt     = 3'b111;

  fsm_e       fsm_q, fsm_d;
  logic [6:0] state_q, state_d;
  logic [6:0] state_inc;
  logic       stall;

  // 7-bit add wraps 127 -> 0 on its own.
  assign state_inc = state_q + 7'd1;

  // A stall is a MOC wait in RUN that has not seen Moc yet.
  assign stall = (fsm_q == StRun) && (Mode == ModeWaitMoc) && !Moc;

`ifdef WAIT_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fault_q;
  logic            fault_hit;

  // This stall would bring the count to TIMEOUT; Moc=1 never counts as a
  // stall, so a late Moc on the same cycle still advances normally.
  assign fault_hit = stall && (cnt_q == CntLast);

  // Count consecutive stalled cycles; clear on any non-stalled cycle or fault.
  always_comb begin
    cnt_d = '0;
    if (stall && !fault_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stall counter and sticky fault flag; only Reset clears the flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_q | fault_hit;
    end
  end

  assign Mem_Fault = fault_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{FAULT_STATE, 32'(TIMEOUT)};
  assign Mem_Fault = 1'b0;
`endif

  // Next-state decode: Mode selects the successor while running; HALT holds.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    if (fsm_q == StRun) begin
      unique case (Mode)
        ModeIncr:     state_d = state_inc;
        ModeDispatch: state_d = State_Sel;
        ModeJump:     state_d = Jump_Addr;
        ModeBrt:      state_d = Cond ? Jump_Addr : state_inc;
        ModeFetch:    state_d = FETCH_STATE;
        ModeWaitMoc:  state_d = Moc ? state_inc : state_q;
        ModeBrf:      state_d = Cond ? state_inc : Jump_Addr;
        ModeHalt: begin
          state_d = state_q;
          fsm_d   = StHalt;
        end
        default:      state_d = state_q;
      endcase
`ifdef WAIT_TIMEOUT_EN
      if (fault_hit) begin
        state_d = FAULT_STATE;
      end
`endif
    end
  end

  // State register; Reset aborts waits and HALT immediately.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsm_q   <= StRun;
      state_q <= 7'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
    end
  end

  assign State   = state_q;
  assign Waiting = stall;
  assign Halted  = (fsm_q == StHalt);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a table of directed vectors,
// hand-written reset/halt/timeout sequences, and a randomized run checked
// against a behavioural model. Honours WAIT_TIMEOUT_EN like the design.
module tb_control_sequencer;

  localparam int TIMEOUT = 15;
  localparam int FETCH   = 1;
  localparam int FAULT   = 127;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [6:0] State_Sel = '0;
  logic [2:0] Mode = '0;
  logic [6:0] Jump_Addr = '0;
  logic       Cond = 1'b0;
  logic       Moc = 1'b0;
  logic [6:0] State;
  logic       Waiting;
  logic       Halted;
  logic       Mem_Fault;

  control_sequencer #(
    .FETCH_STATE(7'(FETCH)),
    .TIMEOUT    (TIMEOUT),
    .FAULT_STATE(7'(FAULT))
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .State_Sel(State_Sel),
    .Mode     (Mode),
    .Jump_Addr(Jump_Addr),
    .Cond     (Cond),
    .Moc      (Moc),
    .State    (State),
    .Waiting  (Waiting),
    .Halted   (Halted),
    .Mem_Fault(Mem_Fault)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  int m_state;
  bit m_halt;
  bit m_fault;
  int m_stalls;
  logic wait_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state  = 0;
    m_halt   = 0;
    m_fault  = 0;
    m_stalls = 0;
  endfunction

  function automatic bit model_waiting(input int md, input bit mo);
    return !m_halt && md == 5 && !mo;
  endfunction

  // One microinstruction executed by the model.
  function automatic void model_edge(input int md, input int sel, input int ja, input bit c,
                                     input bit mo);
    bit stalled;
    stalled = 0;
    if (m_halt) begin
      m_stalls = 0;
      return;
    end
    case (md)
      0: m_state = (m_state + 1) % 128;
      1: m_state = sel;
      2: m_state = ja;
      3: m_state = c ? ja : (m_state + 1) % 128;
      4: m_state = FETCH;
      5: if (mo) m_state = (m_state + 1) % 128; else stalled = 1;
      6: m_state = !c ? ja : (m_state + 1) % 128;
      default: m_halt = 1;
    endcase
`ifdef WAIT_TIMEOUT_EN
    if (stalled) begin
      m_stalls++;
      if (m_stalls == TIMEOUT) begin
        m_state  = FAULT;
        m_fault  = 1;
        m_stalls = 0;
      end
    end else begin
      m_stalls = 0;
    end
`endif
  endfunction

  // Drive one microinstruction (starting 1 time unit after an edge), check the
  // combinational Waiting before the edge and registered outputs after it.
  task automatic step(input logic [2:0] md, input logic [6:0] sel, input logic [6:0] ja,
                      input logic c, input logic mo);
    Mode = md; State_Sel = sel; Jump_Addr = ja; Cond = c; Moc = mo;
    #2;
    wait_seen = Waiting;
    check("waiting", 32'(Waiting), 32'(model_waiting(int'(md), mo)));
    @(posedge Clk);
    model_edge(int'(md), int'(sel), int'(ja), c, mo);
    #1;
    check("state", 32'(State), 32'(m_state));
    check("halted", 32'(Halted), 32'(m_halt));
    check("mem_fault", 32'(Mem_Fault), 32'(m_fault));
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check("rst_state", 32'(State), 32'd0);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_fault", 32'(Mem_Fault), 32'd0);
    Reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0] mode;
    logic [6:0] sel;
    logic [6:0] ja;
    logic       cond;
    logic       moc;
    logic [6:0] exp_state;
    logic       exp_wait;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [2:0] md, input logic [6:0] sel, input logic [6:0] ja,
                              input logic c, input logic mo, input logic [6:0] es,
                              input logic ew);
    vec_t v;
    v.mode = md; v.sel = sel; v.ja = ja; v.cond = c; v.moc = mo;
    v.exp_state = es; v.exp_wait = ew;
    vecs.push_back(v);
  endfunction

  logic [6:0] frozen;

  initial begin
    // Directed vectors: mode, sel, jaddr, cond, moc -> state after edge, Waiting.
    add(3'd0, 7'd0, 7'd0, 0, 0, 7'd1, 0);
    add(3'd0, 7'd0, 7'd0, 0, 0, 7'd2, 0);
    add(3'd0, 7'd0, 7'd0, 0, 0, 7'd3, 0);
    add(3'd2, 7'd0, 7'd127, 0, 0, 7'd127, 0);
    add(3'd0, 7'd0, 7'd0, 0, 0, 7'd0, 0);     // wrap
    add(3'd0, 7'd0, 7'd0, 0, 0, 7'd1, 0);
    add(3'd1, 7'd13, 7'd0, 0, 0, 7'd13, 0);   // dispatch
    add(3'd2, 7'd0, 7'd1, 0, 0, 7'd1, 0);
    add(3'd1, 7'd1, 7'd0, 0, 0, 7'd1, 0);     // dispatch to fetch state
    add(3'd2, 7'd0, 7'd20, 0, 0, 7'd20, 0);
    add(3'd3, 7'd0, 7'd40, 1, 0, 7'd40, 0);   // BRT taken
    add(3'd3, 7'd0, 7'd40, 0, 0, 7'd41, 0);   // BRT not taken
    add(3'd6, 7'd0, 7'd40, 0, 0, 7'd40, 0);   // BRF taken
    add(3'd6, 7'd0, 7'd40, 1, 0, 7'd41, 0);   // BRF not taken
    add(3'd4, 7'd9, 7'd9, 0, 0, 7'd1, 0);     // fetch
    add(3'd2, 7'd0, 7'd14, 0, 0, 7'd14, 0);
    add(3'd5, 7'd0, 7'd0, 0, 0, 7'd14, 1);
    add(3'd5, 7'd0, 7'd0, 0, 0, 7'd14, 1);
    add(3'd5, 7'd0, 7'd0, 0, 0, 7'd14, 1);
    add(3'd5, 7'd0, 7'd0, 0, 0, 7'd14, 1);
    add(3'd5, 7'd0, 7'd0, 0, 1, 7'd15, 0);
    add(3'd5, 7'd0, 7'd0, 0, 1, 7'd16, 0);    // Moc already high: no stall

    model_reset();
    #2;
    check("reset_async_state", 32'(State), 32'd0);
    check("reset_halted", 32'(Halted), 32'd0);
    #10;  // t=12, after the first edge
    Reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].mode, vecs[i].sel, vecs[i].ja, vecs[i].cond, vecs[i].moc);
      check($sformatf("vec%0d_state", i), 32'(State), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_wait", i), 32'(wait_seen), 32'(vecs[i].exp_wait));
    end

    // Reset mid-wait: State returns to 0 at once, no residual stall.
    step(3'd2, 7'd0, 7'd14, 0, 0);
    step(3'd5, 7'd0, 7'd0, 0, 0);
    #3;
    pulse_reset();
    step(3'd0, 7'd0, 7'd0, 0, 0);
    check("post_reset_incr", 32'(State), 32'd1);

    // HALT holds state under random inputs until Reset.
    step(3'd2, 7'd0, 7'd77, 0, 0);
    step(3'd7, 7'd0, 7'd0, 0, 0);
    check("halt_entered", 32'(Halted), 32'd1);
    frozen = State;
    for (int i = 0; i < 20; i++) begin
      step(3'($urandom), 7'($urandom), 7'($urandom), 1'($urandom), 1'($urandom));
      check("halt_frozen", 32'(State), 32'(frozen));
    end
    pulse_reset();

`ifdef WAIT_TIMEOUT_EN
    // Timeout after 15 stalled cycles; fault is sticky.
    step(3'd2, 7'd0, 7'd14, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      step(3'd5, 7'd0, 7'd0, 0, 0);
      check("to_state", 32'(State), (i == 15) ? 32'd127 : 32'd14);
    end
    check("to_fault", 32'(Mem_Fault), 32'd1);
    step(3'd0, 7'd0, 7'd0, 0, 0);
    check("to_sticky", 32'(Mem_Fault), 32'd1);
    pulse_reset();
    // Moc arriving on the 15th cycle wins.
    step(3'd2, 7'd0, 7'd14, 0, 0);
    for (int i = 1; i <= 15; i++) step(3'd5, 7'd0, 7'd0, 0, (i == 15));
    check("to_late_moc_state", 32'(State), 32'd15);
    check("to_late_moc_fault", 32'(Mem_Fault), 32'd0);
`else
    // Without the timeout feature a MOC wait stalls indefinitely.
    step(3'd2, 7'd0, 7'd14, 0, 0);
    for (int i = 0; i < 30; i++) step(3'd5, 7'd0, 7'd0, 0, 0);
    check("long_stall_state", 32'(State), 32'd14);
    check("long_stall_fault", 32'(Mem_Fault), 32'd0);
`endif

    // Randomized run against the model.
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      int md;
      if ($urandom_range(0, 99) < 2 || (m_halt && $urandom_range(0, 5) == 0)) pulse_reset();
      md = $urandom_range(0, 7);
      if (md == 7 && $urandom_range(0, 3) != 0) md = $urandom_range(0, 6);
      step(3'(md), 7'($urandom), 7'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter FETCH_STATE, default 7'd1, state entered by FETCH mode and by dispatch of an unknown instruction.
REQ-002 Parameter TIMEOUT, default 15, MOC wait limit in cycles; used only with WAIT_TIMEOUT_EN.
REQ-003 Parameter FAULT_STATE, default 7'd127, state entered on MOC timeout; used only with WAIT_TIMEOUT_EN.
REQ-004 Clk  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 State_Sel  input  7  dispatch target from the instruction encoder.
REQ-007 Mode  input  3  sequencing mode from the current microinstruction.
REQ-008 Jump_Addr  input  7  branch/jump target from the current microinstruction.
REQ-009 Cond  input  1  branch condition from the datapath.
REQ-010 Moc  input  1  memory operation complete.
REQ-011 State  output  7  current control state; addresses the microstore.
REQ-012 Waiting  output  1  high while stalled in a MOC wait.
REQ-013 Halted  output  1  high while in HALT.
REQ-014 Mem_Fault  output  1  sticky MOC-timeout flag; tied 0 without WAIT_TIMEOUT_EN.

Function
REQ-015 The block SHALL be a two-state FSM, RUN and HALT, plus a registered 7-bit State; next State SHALL depend on the current Mode, Jump_Addr, Cond, Moc and State_Sel.
REQ-016 In RUN, the Mode encodings SHALL be:
- 000 INCR: State+1.
- 001 DISPATCH: State_Sel.
- 010 JUMP: Jump_Addr.
- 011 BRT: Jump_Addr if Cond=1, else State+1.
- 100 FETCH: FETCH_STATE.
- 101 WAITMOC: State+1 if Moc=1, else hold.
- 110 BRF: Jump_Addr if Cond=0, else State+1.
- 111 HALT: hold State, go to HALT.
REQ-017 State+1 SHALL wrap modulo 128 (127 -> 0).
REQ-018 Latency SHALL be one cycle per microinstruction; a WAITMOC with Moc already high SHALL advance without a stall cycle.
REQ-019 Waiting SHALL be combinational: high when FSM=RUN, Mode=101 and Moc=0.
REQ-020 HALT SHALL be exited only by Reset; all inputs SHALL be ignored and Halted SHALL be 1.
REQ-021 A DISPATCH with State_Sel=FETCH_STATE SHALL be legal and SHALL skip the instruction.

Reset
REQ-022 Reset SHALL take effect immediately, independent of Clk.
REQ-023 Under Reset: State=7'd0, FSM=RUN, Halted=0, Mem_Fault=0, timeout counter=0.
REQ-024 Reset asserted mid-wait or in HALT SHALL abort the operation with no residual stall.
REQ-025 On the first edge after Reset deasserts, the block SHALL execute state 0's Mode.

Configuration
REQ-026 Macro WAIT_TIMEOUT_EN, when defined:
- A counter SHALL increment each stalled WAITMOC cycle.
- The counter SHALL clear on any non-stalled cycle.
- When a stall would make the counter reach TIMEOUT, State SHALL go to FAULT_STATE and Mem_Fault SHALL set, sticky until Reset.
- Moc=1 on that same cycle SHALL win, giving a normal advance.
REQ-027 With WAIT_TIMEOUT_EN undefined, WAITMOC SHALL stall indefinitely, Mem_Fault SHALL be 0 and no counter logic SHALL exist.

Verification
REQ-028 Reset; Mode=000 for 3 edges -> State 0,1,2,3; then force State=127 with Mode=000 -> State=0.
REQ-029 At State=1, Mode=001, State_Sel=7'd13 -> State=13 next cycle; with State_Sel=7'd1 -> State=1.
REQ-030 BRT and BRF with Jump_Addr=40:
- BRT, Cond=1 -> State=40; BRT, Cond=0 -> State+1.
- BRF, Cond=0 -> State=40; BRF, Cond=1 -> State+1.
REQ-031 At State=14, Mode=101, Moc=0 for 4 cycles then 1 -> State stays 14 with Waiting=1 for 4 cycles, then 15 with Waiting=0. Repeat with Reset pulsed on the 2nd cycle -> State=0 immediately.
REQ-032 With WAIT_TIMEOUT_EN and TIMEOUT=15, Moc held 0 -> State=127 and Mem_Fault=1 after 15 stalled cycles. Repeat with Moc=1 on the 15th cycle -> normal advance, Mem_Fault=0.
REQ-033 Mode=111 -> Halted=1 and State frozen for 20 cycles under random inputs; Reset -> State=0, Halted=0.
